// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch front end.
package cpu_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with a flush that empties it in one cycle.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output fetch_entry_t               head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem_r [DEPTH];
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            count_r <= count_r + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // Entry storage; contents are masked at the output while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head_valid = (count_r != {CW{1'b0}});
    assign head_data  = head_valid ? mem_r[rd_ptr_r] : '0;
    assign count      = count_r;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between a 1-cycle instruction memory and decode.
// Optional statistics counters are built when PREFETCH_STATS_EN is defined.
module instr_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    output logic                out_valid,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    input  logic                out_ready,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]         stat_flushes,
    output logic [31:0]         stat_stalls
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  fetch_pc_r;
    logic [ADDR_W-1:0]  inflight_pc_r;
    logic               inflight_r;
    logic               drop_r;

    logic [CW-1:0]      count_s;
    logic [CW:0]        occupancy_s;
    logic               issue_s;
    logic               push_s;
    logic               pop_s;
    logic               head_valid_s;
    fetch_entry_t       head_data_s;
    fetch_entry_t       push_data_s;

    // Credit check counts the in-flight fetch so a returning response always has a slot.
    assign occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
    assign issue_s     = !reset && !redirect_valid && (occupancy_s < (CW+1)'(DEPTH));
    assign push_s      = inflight_r && !drop_r && !redirect_valid;
    assign pop_s       = head_valid_s && out_ready && !redirect_valid;
    assign push_data_s = '{pc: inflight_pc_r, instr: imem_instr};

    // Fetch address generation and in-flight tracking; a redirect overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= {ADDR_W{1'b0}};
            inflight_pc_r <= {ADDR_W{1'b0}};
            inflight_r    <= 1'b0;
            drop_r        <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            inflight_r <= 1'b0;
            drop_r     <= 1'b1;
        end else begin
            inflight_r <= issue_s;
            drop_r     <= 1'b0;
            if (issue_s) begin
                fetch_pc_r    <= fetch_pc_r + PC_INC;
                inflight_pc_r <= fetch_pc_r;
            end
        end
    end

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_data  (push_data_s),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s),
        .count      (count_s)
    );

    assign imem_req  = issue_s;
    assign imem_addr = fetch_pc_r;
    assign out_valid = head_valid_s;
    assign out_instr = head_data_s.instr;
    assign out_pc    = head_data_s.pc;

`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_flushes_r;
    logic [31:0] stat_stalls_r;

    // Saturating redirect and decode-stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_flushes_r <= 32'd0;
            stat_stalls_r  <= 32'd0;
        end else begin
            if (redirect_valid) begin
                stat_flushes_r <= sat_inc32(stat_flushes_r);
            end
            if (head_valid_s && !out_ready) begin
                stat_stalls_r <= sat_inc32(stat_stalls_r);
            end
        end
    end

    assign stat_flushes = stat_flushes_r;
    assign stat_stalls  = stat_stalls_r;
`endif

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch unit sitting between the instruction memory and the IF/ID pipeline register of the pipelined ARM CPU. It generates fetch addresses, issues requests to a fixed 1-cycle-latency instruction memory, buffers returned instructions with their PCs in a small FIFO, and hands them to the decode side over a valid/ready handshake. Branch redirects from the execute stage flush the queue and discard in-flight fetches; decode stalls simply deassert ready.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- ADDR_W, 64, PC width
- INSTR_W, 32, instruction width

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  fetch address, valid when imem_req
- imem_instr  in  INSTR_W  instruction for request issued previous cycle
- out_valid  out  1  head entry valid
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  PC of head instruction
- out_ready  in  1  decode accepts head (low = stall)
- redirect_valid  in  1  branch taken, flush and refetch
- redirect_pc  in  ADDR_W  new fetch PC
- (PREFETCH_STATS_EN only) stat_flushes  out  32  redirect count
- (PREFETCH_STATS_EN only) stat_stalls  out  32  cycles with out_valid & ~out_ready

## Operation
- State: fetch_pc, count (0..DEPTH), rd/wr pointers (mod DEPTH), inflight flag, inflight_pc, drop flag.
- Issue rule: imem_req = ~reset & ~redirect_valid & (count + inflight < DEPTH); imem_addr = fetch_pc; on issue fetch_pc += 4 (mod 2^ADDR_W), inflight set next cycle with inflight_pc = issued address.
- Response: cycle after issue, if inflight & ~drop, {imem_instr, inflight_pc} written at wr_ptr, wr_ptr++.
- Pop: out_valid & out_ready & ~redirect_valid → rd_ptr++.
- Push and pop in same cycle: count unchanged; legal when count == DEPTH (credit rule prevents overflow).
- Redirect (highest priority): count, pointers cleared; pending response marked drop; fetch_pc <= redirect_pc; no issue and no pop in the redirect cycle. Handshake coinciding with redirect is void.
- Back-to-back redirects: last one wins; each increments stat_flushes.
- out_* are registered from FIFO storage; out_instr/out_pc don't-care when out_valid low.

## Timing
- Reset values: imem_req 0, imem_addr 0, out_valid 0, out_instr 0, out_pc 0, fetch_pc 0, count 0, stats 0.
- Reset mid-operation: all state cleared next edge; in-flight response discarded.
- First cycle after reset release: imem_req=1, addr 0. Instruction at PC 0 visible on out_valid two cycles after reset release.
- Steady state with out_ready high: one instruction per cycle.
- Redirect at cycle N: out_valid 0 in N+1; request to redirect_pc at N+1; its instruction on out_valid at N+3.
- Full queue with ready low: imem_req stays 0, no data lost; on ready rising, refill resumes the next cycle.

## Configuration
- PREFETCH_STATS_EN defined: stat_flushes, stat_stalls ports and 32-bit saturating counters present, cleared by reset.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Shared package cpu_pkg: ADDR_W, INSTR_W, PC increment constant (4), fetch entry struct {pc, instr}.
- One sub-module: prefetch_fifo (parameterised DEPTH storage, pointers, count, flush input).

## Test plan
- Reset release, out_ready=1, imem returns PC-tagged words → out_pc 0,4,8,12… one per cycle, first at cycle 2.
- out_ready=0 for 10 cycles → count reaches 4, imem_req low, exactly 4 requests issued; release → PCs 0..12 then 16 with no gap or duplicate.
- redirect_valid with redirect_pc=0x100 while queue holds 3 entries and one in flight → out_valid 0 next cycle, no stale PC ever emitted, out_pc 0x100 three cycles later.
- Redirect coinciding with out_valid&out_ready → head not counted as consumed, next output is 0x100 (then 0x104).
- fetch_pc at 0xFFFF_FFFF_FFFF_FFFC → next fetch address wraps to 0.
- With PREFETCH_STATS_EN: 2 redirects and 5 stall cycles → stat_flushes=2, stat_stalls=5; reset clears both.
